// File: rtl/cpu_pkg.sv
// Shared constants and enumerations for the fetch stage of the MIPS core.
// Default address-map values and the redirect/fetch-state encodings.
package cpu_pkg;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC   = 32'hBFC0_0380;
    localparam int          STEP      = 4;

    typedef enum logic [2:0] {
        RD_NONE,
        RD_BR,
        RD_J,
        RD_JR,
        RD_ERET,
        RD_EXC
    } rd_src_e;

    typedef enum logic {
        HOLD,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/pc_target_sel.sv
// Redirect source priority encoder and target address generation.
// Purely combinational: reports {valid, is_flush, target} for the current cycle.
module pc_target_sel #(
    parameter int                ADDR_W  = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(cpu_pkg::EXC_VEC),
    parameter int                STEP    = cpu_pkg::STEP
) (
    input  logic              branch_en,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       br_offset,
    input  logic              jump_en,
    input  logic [25:0]       jump_index,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic              valid,
    output logic              is_flush,
    output logic [ADDR_W-1:0] target
);

    import cpu_pkg::*;

    rd_src_e           src;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] br_off_ext;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;

    // Branch and jump targets are relative to the delay-slot address.
    assign seq_pc     = br_pc + ADDR_W'(STEP);
    assign br_off_ext = {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};
    assign br_target  = seq_pc + br_off_ext;

    generate
        if (ADDR_W > 28) begin : g_j_region
            assign j_target = {seq_pc[ADDR_W-1:28], jump_index, 2'b00};
        end else begin : g_j_flat
            assign j_target = {jump_index, 2'b00};
        end
    endgenerate

    // NOTE: every variable written here gets a default first, so no path infers a latch.
    always_comb begin
        src = RD_NONE;
        if (exc_req)
            src = RD_EXC;
        else if (eret_req)
            src = RD_ERET;
        else if (jr_en)
            src = RD_JR;
        else if (jump_en)
            src = RD_J;
        else if (branch_en && branch_taken)
            src = RD_BR;
    end

    always_comb begin
        valid    = 1'b1;
        is_flush = 1'b0;
        target   = '0;
        case (src)
            RD_EXC: begin
                is_flush = 1'b1;
                target   = EXC_VEC;
            end
            RD_ERET: begin
                is_flush = 1'b1;
                target   = epc;
            end
            RD_JR:   target = jr_target;
            RD_J:    target = j_target;
            RD_BR:   target = br_target;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-request unit: PC register, pending-redirect buffer
// and a two-state start-up FSM in front of the instruction memory port.
module pc_fetch_ctrl #(
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(cpu_pkg::RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(cpu_pkg::EXC_VEC),
    parameter int                STEP      = cpu_pkg::STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              req_ready,
    input  logic              branch_en,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       br_offset,
    input  logic              jump_en,
    input  logic [25:0]       jump_index,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              fetch_adel,
    output logic              redirect_pending
);

    import cpu_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    logic              sel_valid;
    logic              sel_flush;
    logic [ADDR_W-1:0] sel_target;
    logic              advance;

    pc_target_sel #(
        .ADDR_W  (ADDR_W),
        .EXC_VEC (EXC_VEC),
        .STEP    (STEP)
    ) u_target_sel (
        .branch_en    (branch_en),
        .branch_taken (branch_taken),
        .br_pc        (br_pc),
        .br_offset    (br_offset),
        .jump_en      (jump_en),
        .jump_index   (jump_index),
        .jr_en        (jr_en),
        .jr_target    (jr_target),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .valid        (sel_valid),
        .is_flush     (sel_flush),
        .target       (sel_target)
    );

    assign ce      = (state_q == RUN);
    assign advance = ce & req_ready & ~stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        case (state_q)
            HOLD: state_d = RUN;
            RUN:  state_d = RUN;
        endcase

        // Flushes ignore stall/back-pressure; other redirects wait for an accepted fetch.
        if (sel_valid && sel_flush) begin
            pc_d         = sel_target;
            pend_valid_d = 1'b0;
        end else if (sel_valid) begin
            if (advance) begin
                pc_d         = sel_target;
                pend_valid_d = 1'b0;
            end else begin
                pend_valid_d  = 1'b1;
                pend_target_d = sel_target;
            end
        end else if (advance) begin
            if (pend_valid_q) begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end else begin
                pc_d = pc_q + ADDR_W'(STEP);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the pending target is reset too; it is a single register, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HOLD;
            pc_q          <= RESET_VEC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = pend_valid_q;
    assign fetch_adel       = ce & (pc_q[1:0] != 2'b00);

endmodule
